// File: rtl/dot_row_scheduler_pkg.sv
// Shared definitions for the dot-product row scheduler and future layer controllers:
// FSM state encodings, FP32 constants and the row-index width helper.
package dot_row_scheduler_pkg;

    localparam int unsigned FP32_W = 32;
    localparam logic [FP32_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Row index width: clog2 of the row count, never narrower than one bit.
    function automatic int unsigned row_idx_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/dot_row_scheduler_fp_relu.sv
// FP32 ReLU: negative values become +0.0, -0.0 and non-negative values pass unchanged.
// Only compiled when DOT_ROW_SCHED_RELU_EN is defined.
`ifdef DOT_ROW_SCHED_RELU_EN
module fp_relu
    import dot_row_scheduler_pkg::*;
(
    input  logic [FP32_W-1:0] i_val,
    output logic [FP32_W-1:0] o_val_c
);

    always_comb begin
        o_val_c = i_val;
        if (i_val[FP32_W-1] && (i_val[FP32_W-2:0] != '0)) begin
            o_val_c = FP_POS_ZERO;
        end
    end

endmodule
`endif

// File: rtl/dot_row_scheduler.sv
// Sequences one shared dot-product engine over the rows of a job, one row in flight,
// writing each fp32 result to the layer output buffer. DOT_ROW_SCHED_RELU_EN adds ReLU.
module dot_row_scheduler
    import dot_row_scheduler_pkg::*;
#(
    parameter  int unsigned ROWS   = 16,
    parameter  int unsigned BUFLEN = 64,
    localparam int unsigned RW     = row_idx_w(ROWS),
    localparam int unsigned CW     = RW + 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [31:0]       i_job_rows,
    input  logic [31:0]       i_job_vlen,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_vlen,
    output logic [RW-1:0]     o_eng_row,
    output logic [31:0]       o_eng_vlen,
    output logic              o_eng_start,
    input  logic              i_eng_done,
    input  logic [FP32_W-1:0] i_eng_result,
    output logic              o_res_we,
    output logic [RW-1:0]     o_res_addr,
    output logic [FP32_W-1:0] o_res_data
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     w_row_nxt;
    logic [CW-1:0]     r_rows_q;
    logic [CW-1:0]     w_rows_clamp;
    logic [31:0]       w_vlen_clamp;
    logic              w_vlen_over;
    logic              w_accept;
    logic              w_last_row;
    logic              w_in_job;
    logic [FP32_W-1:0] w_result;

    logic              r_busy;
    logic              r_done;
    logic              r_err_vlen;
    logic [31:0]       r_eng_vlen;
    logic              r_eng_start;
    logic              r_res_we;
    logic [FP32_W-1:0] r_res_data;

    // Result path: optional ReLU folded in front of the capture register.
`ifdef DOT_ROW_SCHED_RELU_EN
    fp_relu u_fp_relu (
        .i_val   (i_eng_result),
        .o_val_c (w_result)
    );
`else
    assign w_result = i_eng_result;
`endif

    assign w_accept     = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_vlen_over  = i_job_vlen > 32'(BUFLEN);
    assign w_vlen_clamp = w_vlen_over ? 32'(BUFLEN) : i_job_vlen;
    assign w_rows_clamp = (i_job_rows > 32'(ROWS)) ? CW'(ROWS) : CW'(i_job_rows);
    assign w_last_row   = (CW'(r_row) + CW'(1)) >= r_rows_q;
    assign w_in_job     = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_WRITE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and row counter.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_row_nxt   = '0;
                    w_state_nxt = (w_rows_clamp == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_eng_done) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_last_row) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_row_nxt   = r_row + RW'(1);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_abort && w_in_job) begin
            w_state_nxt = ST_IDLE;
            w_row_nxt   = r_row;
        end
    end

    // Outputs are registered from the next state so strobes line up with the state they mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_rows_q    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_vlen  <= 1'b0;
            r_eng_vlen  <= '0;
            r_eng_start <= 1'b0;
            r_res_we    <= 1'b0;
            r_res_data  <= FP_POS_ZERO;
        end else begin
            r_row       <= w_row_nxt;
            r_busy      <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT)
                           || (w_state_nxt == ST_WRITE);
            r_done      <= w_state_nxt == ST_DONE;
            r_eng_start <= w_state_nxt == ST_ISSUE;
            r_res_we    <= w_state_nxt == ST_WRITE;
            if (w_accept) begin
                r_rows_q   <= w_rows_clamp;
                r_eng_vlen <= w_vlen_clamp;
                r_err_vlen <= w_vlen_over;
            end
            if ((r_state == ST_WAIT) && (w_state_nxt == ST_WRITE)) begin
                r_res_data <= w_result;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err_vlen  = r_err_vlen;
    assign o_eng_row   = r_row;
    assign o_eng_vlen  = r_eng_vlen;
    assign o_eng_start = r_eng_start;
    assign o_res_we    = r_res_we;
    assign o_res_addr  = r_row;
    assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_dot_row_scheduler.sv
// Directed bench for dot_row_scheduler with ROWS=4, BUFLEN=64 and a fixed-latency engine model.
module tb_dot_row_scheduler;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned BUFLEN = 64;
    localparam int unsigned RW     = 2;
    localparam int          L      = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [31:0]   i_job_rows = '0;
    logic [31:0]   i_job_vlen = '0;
    logic          o_busy, o_done, o_err_vlen, o_eng_start, o_res_we;
    logic [RW-1:0] o_eng_row, o_res_addr;
    logic [31:0]   o_eng_vlen, o_res_data;
    logic          i_eng_done = 1'b0;
    logic [31:0]   i_eng_result = '0;
    logic          inj_done = 1'b0;

    logic [31:0]   res_tab [0:3];
    logic [RW-1:0] wr_addr [0:63];
    logic [31:0]   wr_data [0:63];
    int            n_st = 0;
    int            n_we = 0;
    int            n_done = 0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    dot_row_scheduler #(.ROWS(ROWS), .BUFLEN(BUFLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_job_rows   (i_job_rows),
        .i_job_vlen   (i_job_vlen),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err_vlen   (o_err_vlen),
        .o_eng_row    (o_eng_row),
        .o_eng_vlen   (o_eng_vlen),
        .o_eng_start  (o_eng_start),
        .i_eng_done   (i_eng_done),
        .i_eng_result (i_eng_result),
        .o_res_we     (o_res_we),
        .o_res_addr   (o_res_addr),
        .o_res_data   (o_res_data)
    );

    // Engine model: eng_done L cycles after the eng_start cycle; zero length returns +0.0.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            i_eng_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        i_eng_done   = 1'b1;
                        i_eng_result = (o_eng_vlen == 0) ? 32'h0 : res_tab[o_eng_row];
                    end
                end
                if (o_eng_start) cnt = L;
            end
            if (inj_done) begin
                i_eng_done   = 1'b1;
                i_eng_result = 32'h4040_0000;
            end
        end
    end

    // Output monitor, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_eng_start) n_st++;
            if (o_res_we) begin
                wr_addr[n_we % 64] = o_res_addr;
                wr_data[n_we % 64] = o_res_data;
                n_we++;
            end
            if (o_done) n_done++;
        end
    end

    function automatic logic [31:0] exp_res(input logic [31:0] raw);
`ifdef DOT_ROW_SCHED_RELU_EN
        if (raw[31] && raw != 32'h8000_0000) return 32'h0;
`endif
        return raw;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input logic [31:0] rows, input logic [31:0] vlen);
        @(negedge clk);
        i_start    = 1'b1;
        i_job_rows = rows;
        i_job_vlen = vlen;
        @(posedge clk);
        #2;
        i_start = 1'b0;
    endtask

    // Latency counts rising edges from the one that samples start up to the done pulse.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!o_done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({o_busy, o_done, o_err_vlen, o_eng_start, o_res_we} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes got=%b exp=00000",
                            {o_busy, o_done, o_err_vlen, o_eng_start, o_res_we});
        end
        total++;
        if ({o_eng_vlen, o_res_data, o_eng_row, o_res_addr} !== '0) begin
            bad++; $display("FAIL reset_buses got=%0h/%0h exp=0/0", o_eng_vlen, o_res_data);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        total++;
        if ({o_busy, o_done, o_eng_start, o_res_we} !== 4'b0) begin
            bad++; $display("FAIL reset_idle got=%b exp=0000", {o_busy, o_done, o_eng_start, o_res_we});
        end
    endtask

    task automatic test_basic();
        int s0, w0, d0, lat;
        s0 = n_st; w0 = n_we; d0 = n_done;
        start_job(3, 8);
        total++;
        if ({o_busy, o_eng_start, o_eng_row} !== {1'b1, 1'b1, 2'd0}) begin
            bad++; $display("FAIL basic_issue got=%b/%b/%0d exp=1/1/0", o_busy, o_eng_start, o_eng_row);
        end
        wait_done(lat);
        total++;
        if (lat !== 22) begin bad++; $display("FAIL basic_latency got=%0d exp=22", lat); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", o_busy); end
        total++;
        if ((n_st - s0) !== 3 || (n_we - w0) !== 3) begin
            bad++; $display("FAIL basic_counts got=%0d/%0d exp=3/3", n_st - s0, n_we - w0);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wr_addr[(w0 + i) % 64] !== RW'(i) || wr_data[(w0 + i) % 64] !== exp_res(res_tab[i])) begin
                bad++; $display("FAIL basic_write%0d got=%0d:%h exp=%0d:%h", i, wr_addr[(w0 + i) % 64],
                                wr_data[(w0 + i) % 64], i, exp_res(res_tab[i]));
            end
        end
        total++;
        if ({o_err_vlen, o_eng_vlen} !== {1'b0, 32'd8}) begin
            bad++; $display("FAIL basic_vlen got=%b/%0d exp=0/8", o_err_vlen, o_eng_vlen);
        end
        tick();
        total++;
        if (o_done !== 1'b0 || (n_done - d0) !== 1) begin
            bad++; $display("FAIL basic_done_pulse got=%b/%0d exp=0/1", o_done, n_done - d0);
        end
    endtask

    task automatic test_zero_rows();
        int s0, w0, lat;
        s0 = n_st; w0 = n_we;
        start_job(0, 8);
        wait_done(lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL zero_rows_latency got=%0d exp=1", lat); end
        tick();
        total++;
        if ((n_st - s0) !== 0 || (n_we - w0) !== 0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL zero_rows_activity got=%0d/%0d/%b exp=0/0/0", n_st - s0, n_we - w0, o_busy);
        end
    endtask

    task automatic test_start_while_busy();
        int w0, lat;
        w0 = n_we;
        start_job(2, 8);
        repeat (3) tick();
        start_job(4, 8);
        wait_done(lat);
        total++;
        if (lat !== 15 - 4 || (n_we - w0) !== 2) begin
            bad++; $display("FAIL busy_start_ignored got=%0d/%0d exp=11/2", lat, n_we - w0);
        end
        start_job(3, 8);
        total++;
        if (o_busy !== 1'b0 || o_eng_start !== 1'b0) begin
            bad++; $display("FAIL start_in_done got=%b/%b exp=0/0", o_busy, o_eng_start);
        end
        w0 = n_we;
        start_job(1, 8);
        wait_done(lat);
        total++;
        if (lat !== 8 || (n_we - w0) !== 1) begin
            bad++; $display("FAIL back_to_back got=%0d/%0d exp=8/1", lat, n_we - w0);
        end
        tick();
    endtask

    task automatic test_abort();
        int s0, w0, d0, k, lat;
        s0 = n_st; w0 = n_we; d0 = n_done;
        start_job(3, 8);
        k = 0;
        while ((n_st - s0) < 2 && k < 50) begin tick(); k++; end
        total++;
        if ((n_st - s0) !== 2) begin bad++; $display("FAIL abort_reach_row1 got=%0d exp=2", n_st - s0); end
        tick();
        @(negedge clk);
        i_abort = 1'b1;
        @(posedge clk);
        #2;
        i_abort = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_res_we !== 1'b0) begin
            bad++; $display("FAIL abort_exit got=%b/%b exp=0/0", o_busy, o_res_we);
        end
        repeat (15) tick();
        total++;
        if ((n_we - w0) !== 1 || (n_done - d0) !== 0 || (n_st - s0) !== 2) begin
            bad++; $display("FAIL abort_quiet got=%0d/%0d/%0d exp=1/0/2", n_we - w0, n_done - d0, n_st - s0);
        end
        @(negedge clk);
        i_abort = 1'b1; i_start = 1'b1; i_job_rows = 3; i_job_vlen = 8;
        @(posedge clk);
        #2;
        i_abort = 1'b0; i_start = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_eng_start !== 1'b0) begin
            bad++; $display("FAIL abort_beats_start got=%b/%b exp=0/0", o_busy, o_eng_start);
        end
        w0 = n_we;
        start_job(2, 8);
        total++;
        if (o_eng_start !== 1'b1 || o_eng_row !== 2'd0) begin
            bad++; $display("FAIL restart_row0 got=%b/%0d exp=1/0", o_eng_start, o_eng_row);
        end
        wait_done(lat);
        total++;
        if (lat !== 15 || (n_we - w0) !== 2 || wr_addr[(w0 + 1) % 64] !== 2'd1) begin
            bad++; $display("FAIL restart_job got=%0d/%0d exp=15/2", lat, n_we - w0);
        end
        tick();
    endtask

    task automatic test_vlen_clamp();
        int w0, lat;
        w0 = n_we;
        start_job(4, 100);
        total++;
        if (o_err_vlen !== 1'b1 || o_eng_vlen !== 32'd64) begin
            bad++; $display("FAIL vlen_clamp got=%b/%0d exp=1/64", o_err_vlen, o_eng_vlen);
        end
        wait_done(lat);
        total++;
        if (lat !== 29 || (n_we - w0) !== 4) begin
            bad++; $display("FAIL clamp_job got=%0d/%0d exp=29/4", lat, n_we - w0);
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (wr_data[(w0 + i) % 64] !== exp_res(res_tab[i])) begin
                bad++; $display("FAIL clamp_data%0d got=%h exp=%h", i, wr_data[(w0 + i) % 64], exp_res(res_tab[i]));
            end
        end
        tick();
        total++;
        if (o_err_vlen !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", o_err_vlen); end
    endtask

    task automatic test_zero_vlen_rows_clamp();
        int s0, w0, lat;
        s0 = n_st; w0 = n_we;
        start_job(100, 0);
        total++;
        if (o_err_vlen !== 1'b0 || o_eng_vlen !== 32'd0) begin
            bad++; $display("FAIL err_cleared got=%b/%0d exp=0/0", o_err_vlen, o_eng_vlen);
        end
        wait_done(lat);
        total++;
        if (lat !== 29 || (n_st - s0) !== 4 || (n_we - w0) !== 4) begin
            bad++; $display("FAIL rows_clamp got=%0d/%0d/%0d exp=29/4/4", lat, n_st - s0, n_we - w0);
        end
        total++;
        if (wr_data[(w0 + 3) % 64] !== 32'h0 || wr_addr[(w0 + 3) % 64] !== 2'd3) begin
            bad++; $display("FAIL zero_vlen_data got=%0d:%h exp=3:0", wr_addr[(w0 + 3) % 64], wr_data[(w0 + 3) % 64]);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int w0, d0, k;
        start_job(3, 8);
        k = 0;
        while (!o_res_we && k < 40) begin tick(); k++; end
        total++;
        if (o_res_we !== 1'b1) begin bad++; $display("FAIL rst_reach_write got=%b exp=1", o_res_we); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({o_busy, o_res_we, o_eng_start, o_done, o_eng_vlen, o_res_data} !== '0) begin
            bad++; $display("FAIL async_reset got=%b%b/%0d/%h exp=00/0/0", o_busy, o_res_we, o_eng_vlen, o_res_data);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        w0 = n_we; d0 = n_done;
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (5) tick();
        total++;
        if ((n_we - w0) !== 0 || (n_done - d0) !== 0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL late_eng_done got=%0d/%0d/%b exp=0/0/0", n_we - w0, n_done - d0, o_busy);
        end
    endtask

    initial begin
        res_tab[0] = 32'h3F80_0000;
        res_tab[1] = 32'hC000_0000;
        res_tab[2] = 32'h4040_0000;
        res_tab[3] = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        test_basic();
        test_zero_rows();
        test_start_while_busy();
        test_abort();
        test_vlen_clamp();
        test_zero_vlen_rows_clamp();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
